// File: rtl/serv_dec_sched_if.sv
// serv_dec_sched_if -- bundle of the fetch bus, the decoder load port and the
// serial-count / format-decode outputs of serv_dec_sched.
//
// Signals (named from the scheduler's point of view):
//   en          run enable into the scheduler
//   ibus_cyc    fetch request out, ibus_ack/ibus_rdt single-cycle response in
//   wb_en       one-cycle load strobe, wb_rdt instruction bits [31:2]
//   stall       pauses bit-serial counting
//   cnt_en/cnt_done/cnt        serial counter outputs
//   immdec_en/ctrl/csr_imm_en/illegal   format decode outputs
//
// Handshake: ibus is a request/acknowledge pair. ibus_cyc stays high for the
// whole fetch; the responder raises ibus_ack for exactly one cycle with
// ibus_rdt valid in that same cycle. An ack while ibus_cyc is low is ignored.
interface serv_dec_sched_if;
  logic        en;
  logic        ibus_cyc;
  logic        ibus_ack;
  logic [31:0] ibus_rdt;
  logic        wb_en;
  logic [29:0] wb_rdt;
  logic        stall;
  logic        cnt_en;
  logic        cnt_done;
  logic [4:0]  cnt;
  logic [3:0]  immdec_en;
  logic [3:0]  ctrl;
  logic        csr_imm_en;
  logic        illegal;
  logic [1:0]  dbg_state;

  // master: the environment driving the scheduler (bus responder, enables)
  modport master (
    output en, ibus_ack, ibus_rdt, stall,
    input  ibus_cyc, wb_en, wb_rdt, cnt_en, cnt_done, cnt,
           immdec_en, ctrl, csr_imm_en, illegal, dbg_state
  );

  // slave: the scheduler itself
  modport slave (
    input  en, ibus_ack, ibus_rdt, stall,
    output ibus_cyc, wb_en, wb_rdt, cnt_en, cnt_done, cnt,
           immdec_en, ctrl, csr_imm_en, illegal, dbg_state
  );
endinterface

// File: rtl/serv_dec_sched.sv
// serv_dec_sched -- instruction fetch / bit-serial scheduler with format decode.
//
// Fetches one instruction, spends one LOAD cycle presenting it to the
// immediate decoder, then runs 32 bit-serial cycles (pausable by i_stall)
// while presenting the decoded instruction format.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_en                      run enable, sampled in IDLE and at the end of RUN
//   o_ibus_cyc / i_ibus_ack / i_ibus_rdt   fetch request / ack / data
//   o_wb_en, o_wb_rdt         LOAD strobe and captured instruction [31:2]
//   i_stall                   pauses the serial counter
//   o_cnt_en, o_cnt_done, o_cnt            serial counter outputs
//   o_immdec_en, o_ctrl, o_csr_imm_en, o_illegal   format decode (RUN only)
//   o_dbg_state               current FSM state (0 IDLE,1 FETCH,2 LOAD,3 RUN)
module serv_dec_sched #(
  parameter int WITH_CSR = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic        o_ibus_cyc,
  input  logic        i_ibus_ack,
  input  logic [31:0] i_ibus_rdt,
  output logic        o_wb_en,
  output logic [29:0] o_wb_rdt,
  input  logic        i_stall,
  output logic        o_cnt_en,
  output logic        o_cnt_done,
  output logic [4:0]  o_cnt,
  output logic [3:0]  o_immdec_en,
  output logic [3:0]  o_ctrl,
  output logic        o_csr_imm_en,
  output logic        o_illegal,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [29:0] insn_q, insn_d;
  logic [3:0]  immdec_q, immdec_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        csr_q, csr_d;
  logic        ill_q, ill_d;

  // Combinational decode of the captured instruction.
  logic [4:0]  opcode;
  logic        funct3_msb;
  logic [3:0]  dec_immdec;
  logic [3:0]  dec_ctrl;
  logic        dec_ill;
  logic        dec_csr;

  // Instruction bits [1:0] are always 2'b11 for 32-bit encodings and unused.
  logic unused_rdt;
  assign unused_rdt = ^i_ibus_rdt[1:0];

  assign opcode     = insn_q[4:0];   // instruction bits [6:2]
  assign funct3_msb = insn_q[12];    // instruction bit 14

  always_comb begin
    dec_immdec = 4'b0000;
    dec_ctrl   = 4'b0000;
    dec_ill    = 1'b0;
    case (opcode)
      5'b00000, 5'b00100, 5'b11001, 5'b11100: begin
        dec_immdec = 4'b1100;
        dec_ctrl   = 4'b0010;
      end
      5'b01000: begin
        dec_immdec = 4'b1001;
        dec_ctrl   = 4'b0011;
      end
      5'b11000: begin
        dec_immdec = 4'b1001;
        dec_ctrl   = 4'b0101;
      end
      5'b01101, 5'b00101: begin
        dec_immdec = 4'b1010;
        dec_ctrl   = 4'b0000;
      end
      5'b11011: begin
        dec_immdec = 4'b1110;
        dec_ctrl   = 4'b1000;
      end
      5'b01100: begin
        dec_immdec = 4'b0000;
        dec_ctrl   = 4'b0000;
      end
      default: dec_ill = 1'b1;  // unknown opcodes decode as R, flagged
    endcase
    dec_csr = (WITH_CSR != 0) && (opcode == 5'b11100) && funct3_msb;
  end

  logic run;
  logic last_bit;
  assign run      = (state_q == RUN);
  assign last_bit = (cnt_q == 5'd31);

  // Next state, counter and captured-instruction logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    insn_d   = insn_q;
    immdec_d = immdec_q;
    ctrl_d   = ctrl_q;
    csr_d    = csr_q;
    ill_d    = ill_q;
    case (state_q)
      IDLE: begin
        if (i_en) state_d = FETCH;
      end
      FETCH: begin
        if (i_ibus_ack) begin
          insn_d  = i_ibus_rdt[31:2];
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Format registers are loaded here so they are stable for all of RUN.
        immdec_d = dec_immdec;
        ctrl_d   = dec_ctrl;
        csr_d    = dec_csr;
        ill_d    = dec_ill;
        state_d  = RUN;
      end
      RUN: begin
        if (!i_stall) begin
          cnt_d = cnt_q + 5'd1;  // wraps 31 -> 0, ready for the next RUN
          if (last_bit) state_d = i_en ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      insn_q   <= 30'd0;
      immdec_q <= 4'd0;
      ctrl_q   <= 4'd0;
      csr_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      insn_q   <= insn_d;
      immdec_q <= immdec_d;
      ctrl_q   <= ctrl_d;
      csr_q    <= csr_d;
      ill_q    <= ill_d;
    end
  end

  assign o_ibus_cyc   = (state_q == FETCH);
  assign o_wb_en      = (state_q == LOAD);
  assign o_wb_rdt     = insn_q;
  assign o_cnt_en     = run && !i_stall;
  assign o_cnt_done   = run && last_bit;
  assign o_cnt        = cnt_q;
  // Format outputs are forced low outside RUN.
  assign o_immdec_en  = run ? immdec_q : 4'b0000;
  assign o_ctrl       = run ? ctrl_q : 4'b0000;
  assign o_csr_imm_en = run && csr_q;
  assign o_illegal    = run && ill_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_serv_dec_sched.sv
module tb_serv_dec_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serv_dec_sched_if bus ();   // WITH_CSR=1 instance
  serv_dec_sched_if bus1 ();  // WITH_CSR=0 instance, same stimulus

  assign bus1.en       = bus.en;
  assign bus1.ibus_ack = bus.ibus_ack;
  assign bus1.ibus_rdt = bus.ibus_rdt;
  assign bus1.stall    = bus.stall;

  serv_dec_sched #(.WITH_CSR(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(bus.en),
    .o_ibus_cyc(bus.ibus_cyc), .i_ibus_ack(bus.ibus_ack), .i_ibus_rdt(bus.ibus_rdt),
    .o_wb_en(bus.wb_en), .o_wb_rdt(bus.wb_rdt), .i_stall(bus.stall),
    .o_cnt_en(bus.cnt_en), .o_cnt_done(bus.cnt_done), .o_cnt(bus.cnt),
    .o_immdec_en(bus.immdec_en), .o_ctrl(bus.ctrl), .o_csr_imm_en(bus.csr_imm_en),
    .o_illegal(bus.illegal), .o_dbg_state(bus.dbg_state)
  );

  serv_dec_sched #(.WITH_CSR(0)) dut_nocsr (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(bus1.en),
    .o_ibus_cyc(bus1.ibus_cyc), .i_ibus_ack(bus1.ibus_ack), .i_ibus_rdt(bus1.ibus_rdt),
    .o_wb_en(bus1.wb_en), .o_wb_rdt(bus1.wb_rdt), .i_stall(bus1.stall),
    .o_cnt_en(bus1.cnt_en), .o_cnt_done(bus1.cnt_done), .o_cnt(bus1.cnt),
    .o_immdec_en(bus1.immdec_en), .o_ctrl(bus1.ctrl), .o_csr_imm_en(bus1.csr_imm_en),
    .o_illegal(bus1.illegal), .o_dbg_state(bus1.dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [29:0] rdt;
    logic [3:0]  imm;
    logic [3:0]  ctrl;
    logic        csr;
    logic        ill;
    logic [5:0]  len;
  } exp_t;
  localparam int W = $bits(exp_t);

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [29:0] rdt, input logic [3:0] imm,
                              input logic [3:0] ctrl, input logic csr,
                              input logic ill, input logic [5:0] len);
    exp_t e;
    e.rdt = rdt; e.imm = imm; e.ctrl = ctrl; e.csr = csr; e.ill = ill; e.len = len;
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic in_run = 1'b0;
  logic chk_fetch = 1'b0;
  logic exp_fetch = 1'b0;
  int   exp_cnt = 0;
  int   run_cycles = 0;
  exp_t cur = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_run    = 1'b0;
      chk_fetch = 1'b0;
      chk("rst_rdt", {2'b00, bus.wb_rdt}, 32'd0);
      chk("rst_ctl", {bus.ibus_cyc, bus.wb_en, bus.cnt_en, bus.cnt_done, bus.cnt,
                      bus.immdec_en, bus.ctrl, bus.csr_imm_en, bus.illegal}, 32'd0);
    end else begin
      if (chk_fetch) begin
        chk("post_run_cyc", {31'd0, bus.ibus_cyc}, {31'd0, exp_fetch});
        chk_fetch = 1'b0;
      end
      if (in_run) begin
        chk("run_immdec", {28'd0, bus.immdec_en}, {28'd0, cur.imm});
        chk("run_ctrl", {28'd0, bus.ctrl}, {28'd0, cur.ctrl});
        chk("run_csr", {31'd0, bus.csr_imm_en}, {31'd0, cur.csr});
        chk("run_csr_nocsr", {31'd0, bus1.csr_imm_en}, 32'd0);
        chk("run_illegal", {31'd0, bus.illegal}, {31'd0, cur.ill});
        chk("run_cnt", {27'd0, bus.cnt}, exp_cnt);
        chk("run_cnt_en", {31'd0, bus.cnt_en}, {31'd0, !bus.stall});
        chk("run_cnt_done", {31'd0, bus.cnt_done}, {31'd0, exp_cnt == 31});
        run_cycles++;
        if (!bus.stall) begin
          if (exp_cnt == 31) begin
            chk("run_length", run_cycles, {26'd0, cur.len});
            in_run    = 1'b0;
            chk_fetch = 1'b1;
            exp_fetch = bus.en;
          end else begin
            exp_cnt++;
          end
        end
      end else begin
        chk("idle_ctl", {bus.cnt_en, bus.cnt_done, bus.immdec_en, bus.ctrl,
                         bus.csr_imm_en, bus.illegal}, 32'd0);
      end
      if (bus.wb_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb_en", 32'd1, 32'd0);
        end else begin
          cur = exp_t'(exp_q.pop_front());
          chk("load_wb_rdt", {2'b00, bus.wb_rdt}, {2'b00, cur.rdt});
          in_run     = 1'b1;
          exp_cnt    = 0;
          run_cycles = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch(input logic [31:0] insn, input exp_t e);
    int n;
    n = 0;
    exp_q.push_back(W'(e));
    @(negedge clk);
    while (!bus.ibus_cyc && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ibus_cyc) begin
      chk("fetch_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else begin
      bus.ibus_ack = 1'b1;
      bus.ibus_rdt = insn;
      @(posedge clk);
      #1;
      bus.ibus_ack = 1'b0;
      bus.ibus_rdt = $urandom;
    end
  endtask

  // Returns 1 ns after the edge on which the counter leaves value v.
  task automatic wait_cnt(input logic [4:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.cnt == v && bus.cnt_en) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_cnt_timeout", {27'd0, bus.cnt}, {27'd0, v});
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.ibus_ack = 1'b0;
    bus.ibus_rdt = 32'd0;
    bus.stall    = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // No fetch while i_en is low after reset.
    repeat (3) begin
      @(negedge clk);
      chk("no_fetch_en_low", {31'd0, bus.ibus_cyc}, 32'd0);
    end
    @(posedge clk);
    #1 bus.en = 1'b1;

    // addi, sw, beq back-to-back, csrrwi, jal, add
    fetch(32'h0050_0093, mk(30'h0014_0024, 4'b1100, 4'b0010, 1'b0, 1'b0, 6'd32));
    fetch(32'h0011_2223, mk(30'h0004_4888, 4'b1001, 4'b0011, 1'b0, 1'b0, 6'd32));
    fetch(32'h0000_0463, mk(30'h0000_0118, 4'b1001, 4'b0101, 1'b0, 1'b0, 6'd32));
    fetch(32'h3051_5073, mk(30'h0C14_541C, 4'b1100, 4'b0010, 1'b1, 1'b0, 6'd32));
    fetch(32'h0000_006F, mk(30'h0000_001B, 4'b1110, 4'b1000, 1'b0, 1'b0, 6'd32));
    fetch(32'h0000_0033, mk(30'h0000_000C, 4'b0000, 4'b0000, 1'b0, 1'b0, 6'd32));

    // lui with stalls: 3 cycles at cnt 10, 2 cycles at cnt 31
    fetch(32'h0000_12B7, mk(30'h0000_04AD, 4'b1010, 4'b0000, 1'b0, 1'b0, 6'd37));
    wait_cnt(5'd9);
    bus.stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.stall = 1'b0;
    wait_cnt(5'd30);
    bus.stall = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.stall = 1'b0;

    // illegal opcode, i_en dropped mid-RUN
    fetch(32'h0000_007F, mk(30'h0000_001F, 4'b0000, 4'b0000, 1'b0, 1'b1, 6'd32));
    wait_cnt(5'd4);
    bus.en = 1'b0;
    repeat (35) @(posedge clk);
    @(negedge clk);
    chk("idle_after_en_drop", {31'd0, bus.ibus_cyc}, 32'd0);
    @(posedge clk);
    #1 bus.en = 1'b1;

    // asynchronous reset mid-RUN at cnt 17
    fetch(32'h0050_0093, mk(30'h0014_0024, 4'b1100, 4'b0010, 1'b0, 1'b0, 6'd32));
    wait_cnt(5'd16);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdt", {2'b00, bus.wb_rdt}, 32'd0);
    chk("async_rst_ctl", {bus.ibus_cyc, bus.wb_en, bus.cnt_en, bus.cnt_done, bus.cnt,
                          bus.immdec_en, bus.ctrl, bus.csr_imm_en, bus.illegal}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    fetch(32'h0000_0033, mk(30'h0000_000C, 4'b0000, 4'b0000, 1'b0, 1'b0, 6'd32));

    n = 0;
    while ((exp_q.size() != 0 || in_run) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("drain_queue", exp_q.size(), 32'd0);
    chk("drain_run", {31'd0, in_run}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
